// File: rtl/store_aligner_pkg.sv
// store_aligner_pkg: store size codes, lane formation and FIFO entry sizing
package store_aligner_pkg;
  localparam logic [2:0] SW = 3'b000;
  localparam logic [2:0] SH = 3'b001;
  localparam logic [2:0] SB = 3'b010;
  localparam int LANE_W = 36;
  typedef struct packed {
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        legal;
  } lane_t;
  function automatic lane_t lane_form(input logic [2:0] ctl, input logic [1:0] off, input logic [31:0] data);
    lane_t l;
    l.wdata = ctl == SW ? data : ctl == SH ? {2{data[15:0]}} : {4{data[7:0]}};
    l.wstrb = ctl == SW ? 4'b1111 : ctl == SH ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
    l.legal = (ctl == SW && off == 2'b00) || (ctl == SH && !off[0]) || ctl == SB;
    return l;
  endfunction
endpackage

// File: rtl/store_fifo.sv
// store_fifo: DEPTH x W synchronous FIFO with a registered head output
module store_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 68
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] count_q, count_d;
  logic [W-1:0] head_q, head_d;
  logic push, pop;
  assign full_o = count_q == (PW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign head_o = head_q;
  always_comb begin
    push = push_i && !full_o;
    pop = pop_i && !empty_o;
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    // an entry written this edge can already be the next head
    head_d = count_d == '0 ? head_q : (push && wr_q == rd_d) ? din_i : mem_q[rd_d];
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      head_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      count_q <= count_d;
      head_q <= head_d;
    end
  end
endmodule

// File: rtl/store_aligner.sv
// store_aligner: lane-replicates CPU stores, buffers legal writes, flags misaligned ones
module store_aligner
  import store_aligner_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [2:0]    st_ctl,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          mem_wvalid,
  input  logic          mem_wready,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wstrb,
  output logic          misalign,
  output logic [AW-1:0] misalign_addr,
  output logic          busy
);
  localparam int EW = AW + LANE_W;
  lane_t ln;
  logic acc, full, empty, mis_d, mis_q;
  logic [AW-1:0] mis_addr_d, mis_addr_q;
  logic [EW-1:0] head;
  assign ln = lane_form(st_ctl, st_addr[1:0], st_data);
  assign st_ready = !full;
  assign acc = st_valid && st_ready;
  assign mem_wvalid = !empty;
  assign busy = !empty;
  assign mem_waddr = head[EW-1:LANE_W];
  assign mem_wdata = head[LANE_W-1:4];
  assign mem_wstrb = head[3:0];
  assign misalign = mis_q;
  assign misalign_addr = mis_addr_q;
  store_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(acc && ln.legal),
    .din_i({st_addr[AW-1:2], 2'b00, ln.wdata, ln.wstrb}),
    .pop_i(mem_wready),
    .full_o(full),
    .empty_o(empty),
    .head_o(head)
  );
  always_comb begin
    mis_d = acc && !ln.legal;
    mis_addr_d = mis_d ? st_addr : mis_addr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
      mis_addr_q <= '0;
    end else begin
      mis_q <= mis_d;
      mis_addr_q <= mis_addr_d;
    end
  end
endmodule

// File: tb/tb_store_aligner.sv
// tb_store_aligner: directed stimulus checked every cycle against a queue-based store model
module tb_store_aligner;
  localparam int DEPTH = 2;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;
  logic clk = 0, rst_n = 0, st_valid = 0, mem_wready = 0;
  logic st_ready, mem_wvalid, misalign, busy;
  logic [2:0] st_ctl = 0;
  logic [31:0] st_addr = 0, st_data = 0, mem_waddr, mem_wdata, misalign_addr;
  logic [3:0] mem_wstrb;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  ent_t q[$];
  ent_t hold, cur;
  bit mis_e = 0;
  logic [31:0] mis_addr_e = 0;

  store_aligner #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready), .st_ctl(st_ctl),
    .st_addr(st_addr), .st_data(st_data), .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .misalign(misalign),
    .misalign_addr(misalign_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_of(input logic [2:0] c, input logic [31:0] a);
    int off;
    off = int'(a % 4);
    return (c == 3'd0 && off == 0) || (c == 3'd1 && off % 2 == 0) || c == 3'd2;
  endfunction

  function automatic ent_t ent_of(input logic [2:0] c, input logic [31:0] a, input logic [31:0] dt);
    ent_t e;
    int off;
    off = int'(a % 4);
    e.a = a - 32'(off);
    if (c == 3'd0) begin
      e.d = dt;
      e.s = 4'hF;
    end else if (c == 3'd1) begin
      e.d = (dt & 32'hFFFF) * 32'h0001_0001;
      e.s = off >= 2 ? 4'hC : 4'h3;
    end else begin
      e.d = (dt & 32'hFF) * 32'h0101_0101;
      e.s = 4'(1 << off);
    end
    return e;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      mis_e = 0;
      mis_addr_e = 0;
      hold = '{32'h0, 32'h0, 4'h0};
    end else begin
      bit acc;
      acc = st_valid && q.size() < DEPTH;
      mis_e = 0;
      if (mem_wready && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        if (legal_of(st_ctl, st_addr)) q.push_back(ent_of(st_ctl, st_addr, st_data));
        else begin
          mis_e = 1;
          mis_addr_e = st_addr;
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("st_ready", st_ready, q.size() < DEPTH);
    chk("mem_wvalid", mem_wvalid, q.size() != 0);
    chk("busy", busy, q.size() != 0);
    chk("misalign", misalign, mis_e);
    chk("misalign_addr", misalign_addr, mis_addr_e);
    cur = q.size() != 0 ? q[0] : hold;
    chk("mem_waddr", mem_waddr, cur.a);
    chk("mem_wdata", mem_wdata, cur.d);
    chk("mem_wstrb", mem_wstrb, cur.s);
    hold = cur;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d);
    bit ok;
    ok = 0;
    st_valid = 1;
    st_ctl = c;
    st_addr = a;
    st_data = d;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = st_ready;
      step();
    end
    st_valid = 0;
    chk("accept", ok, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && busy; i++) step();
    chk("drain_done", busy, 0);
  endtask

  initial begin
    step();
    step();
    rst_n = 1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_wvalid", mem_wvalid, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_ready", st_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_waddr", mem_waddr, 0);
    step();

    mem_wready = 1;
    send(3'b010, 32'h1003, 32'hAB);
    @(negedge clk);
    chk("sb_valid", mem_wvalid, 1);
    chk("sb_waddr", mem_waddr, 32'h1000);
    chk("sb_wdata", mem_wdata, 32'hABABABAB);
    chk("sb_wstrb", mem_wstrb, 4'b1000);
    step();
    send(3'b001, 32'h2002, 32'h1234);
    @(negedge clk);
    chk("sh_wdata", mem_wdata, 32'h12341234);
    chk("sh_wstrb", mem_wstrb, 4'b1100);
    step();
    send(3'b000, 32'h3000, 32'hDEADBEEF);
    @(negedge clk);
    chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
    chk("sw_wstrb", mem_wstrb, 4'b1111);
    step();
    step();

    send(3'b000, 32'h4001, 32'h1);
    @(negedge clk);
    chk("mis_sw", misalign, 1);
    chk("mis_sw_addr", misalign_addr, 32'h4001);
    chk("mis_sw_novalid", mem_wvalid, 0);
    step();
    @(negedge clk);
    chk("mis_pulse_end", misalign, 0);
    send(3'b001, 32'h4003, 32'h2);
    @(negedge clk);
    chk("mis_sh_addr", misalign_addr, 32'h4003);
    step();
    send(3'b111, 32'h4004, 32'h3);
    @(negedge clk);
    chk("mis_ill", misalign, 1);
    chk("mis_ill_addr", misalign_addr, 32'h4004);
    step();
    step();

    mem_wready = 0;
    send(3'b000, 32'h5000, 32'h11111111);
    send(3'b001, 32'h5006, 32'h2222);
    st_valid = 1;
    st_ctl = 3'b010;
    st_addr = 32'h5009;
    st_data = 32'h33;
    repeat (5) begin
      @(negedge clk);
      chk("full_ready", st_ready, 0);
      chk("hold_waddr", mem_waddr, 32'h5000);
      chk("hold_wdata", mem_wdata, 32'h11111111);
      step();
    end
    mem_wready = 1;
    @(negedge clk);
    chk("ready_before_pop", st_ready, 0);
    step();
    @(negedge clk);
    chk("ready_reraised", st_ready, 1);
    chk("second_waddr", mem_waddr, 32'h5004);
    chk("second_wdata", mem_wdata, 32'h22222222);
    step();
    st_valid = 0;
    drain();
    chk("held_waddr", mem_waddr, 32'h5008);
    chk("held_wstrb", mem_wstrb, 4'b0010);

    for (int i = 0; i < 8; i++) begin
      st_valid = 1;
      st_ctl = i % 2 == 0 ? 3'b000 : 3'b010;
      st_addr = 32'h6000 + 32'(i * 4) + (i % 2 == 0 ? 32'h0 : 32'h3);
      st_data = 32'h0101_0101 * 32'(i + 1);
      step();
      @(negedge clk);
      chk("stream_valid", mem_wvalid, 1);
      chk("stream_ready", st_ready, 1);
    end
    st_valid = 0;
    drain();

    mem_wready = 0;
    send(3'b000, 32'h7000, 32'hCAFEF00D);
    send(3'b010, 32'h7001, 32'h5A);
    rst_n = 0;
    step();
    rst_n = 1;
    @(negedge clk);
    chk("mid_rst_wvalid", mem_wvalid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_waddr", mem_waddr, 0);
    chk("mid_rst_wstrb", mem_wstrb, 0);
    mem_wready = 1;
    repeat (3) step();
    @(negedge clk);
    chk("no_stale", mem_wvalid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/store_aligner.md
Name: store_aligner

Overview:
Store-path counterpart to the load trim/sign-extend stage. It accepts CPU store requests (byte address, register data, size code) and replicates the data onto the correct 32-bit word lanes with byte strobes. Aligned writes are buffered in a small FIFO and drained to data memory over a valid/ready write port. It sits between the MEM-stage store issue and the data RAM / bus write port, and flags misaligned or illegal stores instead of writing them.

Parameters:
DEPTH, 2, number of buffered aligned writes; power of two, at least 2.
AW, 32, address width.

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
st_valid  in  1  store request valid
st_ready  out  1  request accepted when st_valid and st_ready are both high on a rising edge
st_ctl  in  3  size code: SW=3'b000, SH=3'b001, SB=3'b010 (same codes as LW/LH/LB); other codes are illegal
st_addr  in  AW  byte address
st_data  in  32  register data, LSB-justified
mem_wvalid  out  1  write valid
mem_wready  in  1  memory accepts the write
mem_waddr  out  AW  word address, {st_addr[AW-1:2],2'b00}
mem_wdata  out  32  lane-replicated data
mem_wstrb  out  4  byte enables
misalign  out  1  one-cycle pulse for a rejected store
misalign_addr  out  AW  address of the most recent rejected store, held until the next reject
busy  out  1  FIFO non-empty

Behaviour:
- Reset: when rst_n is low at a clock edge, all of the following apply. FIFO count = 0, pointers = 0. mem_wvalid = 0, mem_waddr = 0, mem_wdata = 0, mem_wstrb = 0. misalign = 0, misalign_addr = 0, busy = 0. Pending entries are discarded. Reset mid-transfer drops the in-flight write without completing it.
- st_ready = (count != DEPTH). It is registered-state only and has no combinational path from mem_wready.
- Lane formation, with off = st_addr[1:0]:
  - SW: wdata = st_data; wstrb = 4'b1111.
  - SH: wdata = {2{st_data[15:0]}}; wstrb = off[1] ? 4'b1100 : 4'b0011.
  - SB: wdata = {4{st_data[7:0]}}; wstrb = 4'b0001 << off.
- Legality rules:
  - SW requires off = 0.
  - SH requires off[0] = 0.
  - SB is always legal.
  - Any other st_ctl value is illegal.
- Illegal or misaligned request: the handshake still completes (st_ready honoured) but nothing is enqueued. On the next cycle misalign = 1 for exactly one cycle and misalign_addr = st_addr.
- Legal request: the entry {waddr, wdata, wstrb} is pushed on the accept edge.
- Output side: mem_w* are driven from the FIFO head. mem_wvalid = (count != 0).
  - Latency: a request accepted into an empty FIFO at edge N gives mem_wvalid = 1 in the cycle after edge N.
  - Pop occurs on an edge with mem_wvalid && mem_wready.
  - While mem_wvalid is high and mem_wready is low, mem_waddr, mem_wdata and mem_wstrb must hold stable.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: st_ready = 0. A pop on that edge re-raises st_ready in the next cycle, not the same cycle.
- Empty: mem_wvalid = 0. mem_w* data outputs are don't-care but must not be X after reset (they hold the last value).
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Writes issue in program order. No merging or reordering.

Decomposition:
- Shared package:
  - size-code constants SW/SH/SB, with values identical to the load LW/LH/LB codes;
  - a lane function (ctl, off, data) -> {wdata, wstrb, legal};
  - the entry struct/width constant (AW+36).
- One sub-module, store_fifo: a generic DEPTH x width synchronous FIFO with push/pop/full/empty and registered head output. store_aligner adds lane formation, legality checking and the misalign register.

Test Plan:
1. Reset then idle: rst_n low for 2 cycles, then high. Required: mem_wvalid = 0, misalign = 0, st_ready = 1, busy = 0.
2. Lane formation, with mem_wready = 1 held:
   - SB addr 0x1003 data 0xAB gives waddr 0x1000, wdata 0xABABABAB, wstrb 4'b1000.
   - SH addr 0x2002 data 0x1234 gives wdata 0x12341234, wstrb 4'b1100.
   - SW addr 0x3000 data 0xDEADBEEF gives wstrb 4'b1111.
   - Each write appears one cycle after accept.
3. Misalign: SW addr 0x4001, then SH addr 0x4003, then st_ctl = 3'b111.
   - Required: each gives a one-cycle misalign pulse with misalign_addr = 0x4001, then 0x4003, then the third request's address.
   - No mem_wvalid is asserted.
4. Backpressure/full with DEPTH = 2: mem_wready = 0, push 3 legal stores.
   - Required: st_ready drops after the 2nd; outputs stay stable for 5 cycles.
   - Raise mem_wready: writes drain in order, the 3rd is accepted after the first pop, and busy falls after the last pop.
5. Simultaneous push and pop: steady stream with st_valid = 1 and mem_wready = 1 for 8 cycles.
   - Required: throughput of 1 write/cycle, count stays at 1, order preserved, pointer wrap exercised.
6. Reset mid-operation: FIFO full with mem_wready = 0, assert rst_n = 0 for 1 cycle.
   - Required: mem_wvalid = 0 next cycle, busy = 0, and the old entries never appear.
